// File: rtl/fdiv16_if.sv
// fdiv16_if: request/response bundle for the binary16 divider.
//   start      requester -> divider  start a division (taken only when not busy)
//   x, y       requester -> divider  dividend / divisor, binary16
//   roundmode  requester -> divider  00 RZ, 01 RNE, 10 RM, 11 RP
//   busy       divider -> requester  operation in flight
//   done       divider -> requester  one-cycle completion pulse
//   result     divider -> requester  quotient, held until the next completion
//   flags      divider -> requester  {NV, DZ, OF, UF, NX}, held with result
interface fdiv16_if;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  roundmode;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [4:0]  flags;

    modport master (output start, x, y, roundmode, input busy, done, result, flags);
    modport slave  (input start, x, y, roundmode, output busy, done, result, flags);
endinterface

// File: rtl/fdiv16.sv
// fdiv16: sequential binary16 divider, result = x / y.
// Radix-2 restoring divider with a fixed 16-cycle start->done latency for
// every operand class, including NaN/inf/zero special cases.
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation without a done pulse
//   bus    fdiv16_if slave: start/x/y/roundmode in, busy/done/result/flags out
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after RND
// PREP  | classify operands, normalize significands, form the exponent
// DIV   | 13 restoring-division steps, one quotient bit per cycle
// RND   | denormalize tiny results, round, handle overflow, select specials
module fdiv16 (
    input logic     clk,
    input logic     reset,
    fdiv16_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_RND} state_t;

    state_t state_q, state_d;

    logic [15:0]       x_q, y_q;
    logic [1:0]        rm_q;
    logic [12:0]       rem_q, rem_d;
    logic [10:0]       div_q;
    logic [12:0]       quo_q, quo_d;
    logic [3:0]        cnt_q;
    logic signed [7:0] e_q;
    logic              sign_q;
    logic              spec_q;
    logic [15:0]       spec_res_q;
    logic [4:0]        spec_flg_q;
    logic [15:0]       res_q, res_d;
    logic [4:0]        flg_q, flg_d;
    logic              done_q;

    logic accept, ld_prep, step, finish;

    // Returns {exponent(8, signed), significand(11)} with the significand
    // normalized to 1.f; subnormals are shifted up and the exponent lowered.
    function automatic logic [18:0] unpack16(input logic [15:0] v);
        logic [3:0]  lz;
        logic [10:0] m;
        logic [7:0]  e;
        lz = 4'd11;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) lz = 4'(10 - i);
        end
        if (v[14:10] == 5'd0) begin
            m = {1'b0, v[9:0]} << lz;
            e = 8'd1 - {4'd0, lz};
        end else begin
            m = {1'b1, v[9:0]};
            e = {3'd0, v[14:10]};
        end
        unpack16 = {e, m};
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_PREP;
            S_PREP:  state_d = S_DIV;
            S_DIV:   if (cnt_q == 4'd0) state_d = S_RND;
            S_RND:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        accept  = 1'b0;
        ld_prep = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE:  accept  = bus.start;
            S_PREP:  ld_prep = 1'b1;
            S_DIV:   step    = 1'b1;
            S_RND:   finish  = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.flags  = flg_q;

    // ---------------- PREP: classification and alignment ----------------
    logic x_zero, x_inf, x_nan, x_snan;
    logic y_zero, y_inf, y_nan, y_snan;
    logic [18:0] x_unp, y_unp;
    logic signed [7:0] e_pre, e_d;
    logic [11:0] mx_d;
    logic [10:0] my_d;
    logic        sign_d, spec_d;
    logic [15:0] spec_res_d;
    logic [4:0]  spec_flg_d;

    always_comb begin
        x_zero = (x_q[14:10] == 5'd0)  && (x_q[9:0] == 10'd0);
        x_inf  = (x_q[14:10] == 5'h1F) && (x_q[9:0] == 10'd0);
        x_nan  = (x_q[14:10] == 5'h1F) && (x_q[9:0] != 10'd0);
        x_snan = x_nan && !x_q[9];
        y_zero = (y_q[14:10] == 5'd0)  && (y_q[9:0] == 10'd0);
        y_inf  = (y_q[14:10] == 5'h1F) && (y_q[9:0] == 10'd0);
        y_nan  = (y_q[14:10] == 5'h1F) && (y_q[9:0] != 10'd0);
        y_snan = y_nan && !y_q[9];

        x_unp = unpack16(x_q);
        y_unp = unpack16(y_q);
        my_d  = y_unp[10:0];
        e_pre = $signed(x_unp[18:11]) - $signed(y_unp[18:11]) + 8'sd15;
        // Pre-scaling the dividend keeps the quotient in [1,2).
        if (x_unp[10:0] < y_unp[10:0]) begin
            mx_d = {x_unp[10:0], 1'b0};
            e_d  = e_pre - 8'sd1;
        end else begin
            mx_d = {1'b0, x_unp[10:0]};
            e_d  = e_pre;
        end

        sign_d     = x_q[15] ^ y_q[15];
        spec_d     = 1'b1;
        spec_res_d = 16'h0000;
        spec_flg_d = 5'b00000;
        if (x_nan || y_nan) begin
            spec_res_d = 16'h7E00;
            spec_flg_d = {x_snan | y_snan, 4'b0000};
        end else if ((x_zero && y_zero) || (x_inf && y_inf)) begin
            spec_res_d = 16'h7E00;
            spec_flg_d = 5'b10000;
        end else if (x_inf) begin
            spec_res_d = {sign_d, 15'h7C00};
        end else if (y_inf) begin
            spec_res_d = {sign_d, 15'h0000};
        end else if (y_zero) begin
            spec_res_d = {sign_d, 15'h7C00};
            spec_flg_d = 5'b01000;
        end else if (x_zero) begin
            spec_res_d = {sign_d, 15'h0000};
        end else begin
            spec_d = 1'b0;
        end
    end

    // ---------------- DIV: one restoring step ----------------
    logic        rem_ge;
    logic [12:0] rem_sel;

    always_comb begin
        rem_ge  = (rem_q >= {2'b00, div_q});
        rem_sel = rem_ge ? (rem_q - {2'b00, div_q}) : rem_q;
        rem_d   = rem_sel << 1;
        quo_d   = {quo_q[11:0], rem_ge};
    end

    // ---------------- RND: denormalize, round, pack ----------------
    logic        tiny, lost, guard, rbit, sticky, inexact, inc, ovf;
    logic [7:0]  rsh, exp_base;
    logic [4:0]  shamt;
    logic [25:0] ext;
    logic [12:0] q_sh;
    logic [17:0] mag;
    logic signed [7:0] exp_post;
    logic [15:0] ov_res;

    always_comb begin
        tiny  = (e_q <= 8'sd0);
        rsh   = 8'd1 - e_q;
        shamt = (rsh > 8'd26) ? 5'd26 : rsh[4:0];
        ext   = {quo_q, 13'd0} >> shamt;
        if (tiny) begin
            q_sh = ext[25:13];
            lost = |ext[12:0];
        end else begin
            q_sh = quo_q;
            lost = 1'b0;
        end
        guard   = q_sh[1];
        rbit    = q_sh[0];
        sticky  = (rem_q != 13'd0) | lost;
        inexact = guard | rbit | sticky;

        case (rm_q)
            2'b00:   inc = 1'b0;
            2'b01:   inc = guard & (rbit | sticky | q_sh[2]);
            2'b10:   inc = sign_q & inexact;
            default: inc = !sign_q & inexact;
        endcase

        // The hidden bit of a normal significand lands in the exponent field,
        // so the base is e-1; a rounding carry also ripples into the exponent,
        // which turns a subnormal rounding up to 2^-14 into the normal encoding.
        exp_base = tiny ? 8'd0 : 8'(e_q - 8'sd1);
        mag      = {exp_base, 10'd0} + {7'd0, q_sh[12:2]} + {17'd0, inc};
        exp_post = $signed(mag[17:10]);
        ovf      = !tiny && (exp_post >= 8'sd31);

        case (rm_q)
            2'b00:   ov_res = {sign_q, 15'h7BFF};
            2'b01:   ov_res = {sign_q, 15'h7C00};
            2'b10:   ov_res = sign_q ? 16'hFC00 : 16'h7BFF;
            default: ov_res = sign_q ? 16'hFBFF : 16'h7C00;
        endcase

        if (spec_q) begin
            res_d = spec_res_q;
            flg_d = spec_flg_q;
        end else begin
            res_d = ovf ? ov_res : {sign_q, mag[14:0]};
            flg_d = {2'b00, ovf, tiny & inexact, inexact | ovf};
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= 16'h0000;
            y_q        <= 16'h0000;
            rm_q       <= 2'b00;
            rem_q      <= 13'd0;
            div_q      <= 11'd0;
            quo_q      <= 13'd0;
            cnt_q      <= 4'd0;
            e_q        <= 8'sd0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= 16'h0000;
            spec_flg_q <= 5'b00000;
            res_q      <= 16'h0000;
            flg_q      <= 5'b00000;
            done_q     <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                x_q  <= bus.x;
                y_q  <= bus.y;
                rm_q <= bus.roundmode;
            end
            if (ld_prep) begin
                rem_q      <= {1'b0, mx_d};
                div_q      <= my_d;
                quo_q      <= 13'd0;
                cnt_q      <= 4'd12;
                e_q        <= e_d;
                sign_q     <= sign_d;
                spec_q     <= spec_d;
                spec_res_q <= spec_res_d;
                spec_flg_q <= spec_flg_d;
            end
            if (step) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            end
            if (finish) begin
                res_q <= res_d;
                flg_q <= flg_d;
            end
        end
    end
endmodule

// File: tb/tb_fdiv16.sv
module tb_fdiv16;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fdiv16_if bus();
    fdiv16 dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  rm;
        logic [15:0] res;
        logic [4:0]  flg;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    vec_t vt[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got result=%h flags=%b, required no completion",
                         bus.result, bus.flags);
            end else begin
                e = sbq.pop_front();
                n_cmp++;
                if (bus.result !== e.res) begin
                    n_err++;
                    $display("FAIL result: got %h, required %h", bus.result, e.res);
                end
                n_cmp++;
                if (bus.flags !== e.flg) begin
                    n_err++;
                    $display("FAIL flags (result %h): got %b, required %b", e.res, bus.flags, e.flg);
                end
                n_cmp++;
                if (cyc - e.acc != 16) begin
                    n_err++;
                    $display("FAIL latency (result %h): got %0d, required 16", e.res, cyc - e.acc);
                end
            end
        end
    end

    task automatic issue(input vec_t v, input bit push);
        int   w;
        exp_t e;
        w = 0;
        while (bus.busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (bus.busy) begin
            n_err++;
            $display("FAIL issue_timeout: busy=%b after %0d cycles, required 0", bus.busy, w);
        end else begin
            bus.start     = 1'b1;
            bus.x         = v.x;
            bus.y         = v.y;
            bus.roundmode = v.rm;
            if (push) begin
                e.res = v.res;
                e.flg = v.flg;
                e.acc = cyc;
                sbq.push_back(e);
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        int   nb;
        int   t;

        //             x         y        rm     result    flags {NV,DZ,OF,UF,NX}
        vt.push_back('{16'h3C00, 16'h3C00, 2'b01, 16'h3C00, 5'b00000});
        vt.push_back('{16'h3C00, 16'h4200, 2'b01, 16'h3555, 5'b00001});
        vt.push_back('{16'h3C00, 16'h4200, 2'b11, 16'h3556, 5'b00001});
        vt.push_back('{16'h3C00, 16'h4200, 2'b00, 16'h3555, 5'b00001});
        vt.push_back('{16'h3C00, 16'h4200, 2'b10, 16'h3555, 5'b00001});
        vt.push_back('{16'hBC00, 16'h4200, 2'b10, 16'hB556, 5'b00001});
        vt.push_back('{16'h7BFF, 16'h1400, 2'b01, 16'h7C00, 5'b00101});
        vt.push_back('{16'h7BFF, 16'h1400, 2'b00, 16'h7BFF, 5'b00101});
        vt.push_back('{16'hFBFF, 16'h1400, 2'b10, 16'hFC00, 5'b00101});
        vt.push_back('{16'hFBFF, 16'h1400, 2'b11, 16'hFBFF, 5'b00101});
        vt.push_back('{16'hBC00, 16'h0000, 2'b01, 16'hFC00, 5'b01000});
        vt.push_back('{16'h0000, 16'h0000, 2'b01, 16'h7E00, 5'b10000});
        vt.push_back('{16'h7D00, 16'h3C00, 2'b01, 16'h7E00, 5'b10000});
        vt.push_back('{16'h7E00, 16'h3C00, 2'b01, 16'h7E00, 5'b00000});
        vt.push_back('{16'h7C00, 16'hFC00, 2'b01, 16'h7E00, 5'b10000});
        vt.push_back('{16'h7C00, 16'hC000, 2'b01, 16'hFC00, 5'b00000});
        vt.push_back('{16'h3C00, 16'h7C00, 2'b01, 16'h0000, 5'b00000});
        vt.push_back('{16'h8000, 16'h3C00, 2'b01, 16'h8000, 5'b00000});
        vt.push_back('{16'h0400, 16'h4000, 2'b01, 16'h0200, 5'b00000});
        vt.push_back('{16'h0401, 16'h4000, 2'b01, 16'h0200, 5'b00011});
        vt.push_back('{16'h0401, 16'h4000, 2'b11, 16'h0201, 5'b00011});
        vt.push_back('{16'h07FF, 16'h4000, 2'b01, 16'h0400, 5'b00011});
        vt.push_back('{16'h0001, 16'h0001, 2'b01, 16'h3C00, 5'b00000});

        bus.start     = 1'b0;
        bus.x         = 16'h0000;
        bus.y         = 16'h0000;
        bus.roundmode = 2'b00;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        n_cmp++;
        if ({bus.busy, bus.done, bus.result, bus.flags} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h flags=%b, required all 0",
                     bus.busy, bus.done, bus.result, bus.flags);
        end

        // First vector: busy must be high exactly in cycles 1..15.
        issue(vt[0], 1'b1);
        nb = 0;
        for (int k = 1; k <= 16; k++) begin
            if (bus.busy) nb++;
            if (k < 16) @(negedge clk);
        end
        n_cmp++;
        if (nb != 15) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d, required 15", nb);
        end

        // Remaining vectors go back-to-back: each start lands in the done cycle.
        for (int i = 1; i < vt.size(); i++) issue(vt[i], 1'b1);

        // A start while busy must be ignored.
        v = '{16'h4000, 16'h3C00, 2'b01, 16'h4000, 5'b00000};
        issue(v, 1'b1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 16'h3C00;
        bus.y     = 16'h4200;
        @(negedge clk);
        bus.start = 1'b0;

        // Reset at cycle 7 of an operation: aborted, no done, outputs cleared.
        v = '{16'h3C00, 16'h4200, 2'b01, 16'h3555, 5'b00001};
        issue(v, 1'b0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.done, bus.result, bus.flags} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_abort: got busy=%b done=%b result=%h flags=%b, required all 0",
                     bus.busy, bus.done, bus.result, bus.flags);
        end
        repeat (20) @(negedge clk);

        v = '{16'hC500, 16'h4000, 2'b01, 16'hC100, 5'b00000};
        issue(v, 1'b1);

        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sbq.size());
        end
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
